// File: rtl/seg_scan_3digit.sv
// rtl/seg_scan_3digit.sv - three-digit multiplexed 7-segment scanner with dead time and leading-zero blanking
// Digit codes are shadowed once per frame so a frame never mixes old and new values.
module seg_scan_3digit #(
  parameter int TICK_DIV = 50000,
  parameter int DEAD     = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [6:0] digi_0,
  input  logic [6:0] digi_1,
  input  logic [6:0] digi_2,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_start
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [6:0] ZERO = 7'b0111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [6:0]    sh_0;
  logic [6:0]    sh_1;
  logic [6:0]    sh_2;
  logic          sh_bl;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic          b1;
  logic          b2;
  logic [2:0]    an_next;
  logic [6:0]    seg_next;

  assign slot_end  = (cnt == LAST);
  assign frame_end = slot_end && (idx == 2'd2);

  // With no dead time the compare would be constant, so it is elaborated away.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
      assign in_dead = (cnt < DEAD_C);
    end
  endgenerate

  assign b2 = sh_bl && (sh_2 == ZERO);
  assign b1 = b2 && (sh_1 == ZERO);

  always_comb begin
    an_next  = 3'b000;
    seg_next = 7'd0;
    if (!in_dead) begin
      case (idx)
        2'd0: begin
          an_next  = 3'b001;
          seg_next = sh_0;
        end
        2'd1: begin
          an_next  = 3'b010;
          seg_next = b1 ? 7'd0 : sh_1;
        end
        2'd2: begin
          an_next  = 3'b100;
          seg_next = b2 ? 7'd0 : sh_2;
        end
        default: begin
          an_next  = 3'b000;
          seg_next = 7'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sh_0  <= 7'd0;
      sh_1  <= 7'd0;
      sh_2  <= 7'd0;
      sh_bl <= 1'b0;
    end else if (frame_end) begin
      sh_0  <= digi_0;
      sh_1  <= digi_1;
      sh_2  <= digi_2;
      sh_bl <= blank_lead;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= 7'd0;
      an          <= 3'b000;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_next;
      an          <= an_next;
      frame_start <= (idx == 2'd0) && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_3digit.sv
// tb/tb_seg_scan_3digit.sv - self-checking bench for seg_scan_3digit
// Expected outputs come from a frame-level model: edge number -> slot/position, plus per-frame snapshots.
module tb_seg_scan_3digit;

  localparam int TD   = 8;
  localparam int DT   = 2;
  localparam int FLEN = 3 * TD;

  localparam logic [6:0] ZERO   = 7'b0111111;
  localparam logic [6:0] DIGI_0 = 7'b0111111;
  localparam logic [6:0] DIGI_1 = 7'b0011000;
  localparam logic [6:0] DIGI_2 = 7'b1110110;
  localparam logic [6:0] DIGI_3 = 7'b1111100;
  localparam logic [6:0] DIGI_4 = 7'b1011001;
  localparam logic [6:0] DIGI_5 = 7'b1101101;
  localparam logic [6:0] DIGI_9 = 7'b1111101;

  logic       clock;
  logic       rst_n;
  logic [6:0] digi_0;
  logic [6:0] digi_1;
  logic [6:0] digi_2;
  logic       blank_lead;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_start;

  int total;
  int bad;

  int         n;
  logic [6:0] snap [3];
  logic       snap_bl;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_fs;

  seg_scan_3digit #(.TICK_DIV(TD), .DEAD(DT)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .digi_0      (digi_0),
    .digi_1      (digi_1),
    .digi_2      (digi_2),
    .blank_lead  (blank_lead),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; expected values for edge n use the snapshot of the previous frame end.
  task automatic step();
    int k, pos, slot;
    logic bl2, bl1;
    @(posedge clock);
    n++;
    k    = n - 1;
    pos  = k % TD;
    slot = (k / TD) % 3;
    exp_fs = (pos == 0) && (slot == 0);
    if (pos < DT) begin
      exp_an  = 3'b000;
      exp_seg = 7'd0;
    end else begin
      exp_an  = 3'(1 << slot);
      bl2 = snap_bl && (snap[2] == ZERO);
      bl1 = bl2 && (snap[1] == ZERO);
      if ((slot == 2 && bl2) || (slot == 1 && bl1)) exp_seg = 7'd0;
      else exp_seg = snap[slot];
    end
    if (n % FLEN == 0) begin
      snap[0] = digi_0;
      snap[1] = digi_1;
      snap[2] = digi_2;
      snap_bl = blank_lead;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n       = 0;
    snap[0] = 7'd0;
    snap[1] = 7'd0;
    snap[2] = 7'd0;
    snap_bl = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    digi_0 = DIGI_3; digi_1 = DIGI_2; digi_2 = DIGI_1; blank_lead = 1'b0;
    rst_n = 1'b0;
    @(negedge clock);
    total++; if (seg !== 7'd0) begin bad++; $display("FAIL reset_seg got=%b want=%b", seg, 7'd0); end
    total++; if (an !== 3'b000) begin bad++; $display("FAIL reset_an got=%b want=000", an); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
  endtask

  task automatic test_first_frame();
    apply_reset();
    for (int e = 1; e <= 2 * FLEN; e++) begin
      step();
      total++;
      if (seg !== exp_seg || an !== exp_an || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL first_frame_model edge=%0d got seg=%b an=%b fs=%b want seg=%b an=%b fs=%b",
                 n, seg, an, frame_start, exp_seg, exp_an, exp_fs);
      end
      if (e == 1) begin
        total++; if (frame_start !== 1'b1 || an !== 3'b000) begin bad++; $display("FAIL first_edge got fs=%b an=%b want fs=1 an=000", frame_start, an); end
      end
      if (e <= 24) begin
        total++; if (seg !== 7'd0) begin bad++; $display("FAIL first_frame_dark edge=%0d got=%b want=0", e, seg); end
      end
      if (e == 25) begin
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_edge25 got=%b want=1", frame_start); end
      end
      if (e >= 27 && e <= 32) begin
        total++; if (an !== 3'b001 || seg !== 7'b1111100) begin bad++; $display("FAIL digit0 edge=%0d got an=%b seg=%b want 001/1111100", e, an, seg); end
      end
      if (e >= 35 && e <= 40) begin
        total++; if (an !== 3'b010 || seg !== 7'b1110110) begin bad++; $display("FAIL digit1 edge=%0d got an=%b seg=%b want 010/1110110", e, an, seg); end
      end
      if (e >= 43 && e <= 48) begin
        total++; if (an !== 3'b100 || seg !== 7'b0011000) begin bad++; $display("FAIL digit2 edge=%0d got an=%b seg=%b want 100/0011000", e, an, seg); end
      end
    end
  endtask

  task automatic test_dead_time();
    apply_reset();
    for (int e = 1; e <= 10 * FLEN; e++) begin
      step();
      if ($urandom_range(0, 5) == 0) digi_0 = 7'($urandom);
      if ($urandom_range(0, 5) == 0) digi_1 = ($urandom_range(0, 1) == 1) ? ZERO : 7'($urandom);
      if ($urandom_range(0, 5) == 0) digi_2 = ($urandom_range(0, 1) == 1) ? ZERO : 7'($urandom);
      if ($urandom_range(0, 7) == 0) blank_lead = ~blank_lead;
      total++;
      if (seg !== exp_seg || an !== exp_an || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL scan_model edge=%0d got seg=%b an=%b fs=%b want seg=%b an=%b fs=%b",
                 n, seg, an, frame_start, exp_seg, exp_an, exp_fs);
      end
      if ((n - 1) % TD < DT) begin
        total++; if (an !== 3'b000 || seg !== 7'd0) begin bad++; $display("FAIL dead_slot edge=%0d got an=%b seg=%b want 000/0", n, an, seg); end
      end
    end
  endtask

  task automatic test_coherence();
    digi_0 = DIGI_3; digi_1 = DIGI_2; digi_2 = DIGI_1; blank_lead = 1'b0;
    apply_reset();
    for (int e = 1; e <= 56; e++) begin
      step();
      if (e == 29) digi_0 = DIGI_9;
      if (e >= 27 && e <= 32) begin
        total++; if (seg !== 7'b1111100) begin bad++; $display("FAIL coherent_old edge=%0d got=%b want=1111100", e, seg); end
      end
      if (e >= 51 && e <= 56) begin
        total++; if (seg !== 7'b1111101) begin bad++; $display("FAIL coherent_new edge=%0d got=%b want=1111101", e, seg); end
      end
    end
  endtask

  task automatic run_blank_frames(input int frames, input string tag);
    for (int e = 1; e <= frames * FLEN; e++) begin
      step();
      total++;
      if (seg !== exp_seg || an !== exp_an || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL %s edge=%0d got seg=%b an=%b want seg=%b an=%b", tag, n, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_blanking();
    digi_0 = DIGI_5; digi_1 = DIGI_0; digi_2 = DIGI_0; blank_lead = 1'b1;
    apply_reset();
    run_blank_frames(1, "blank_frame0");
    for (int e = 1; e <= FLEN; e++) begin
      step();
      if (e > 2 && e <= 8) begin
        total++; if (an !== 3'b001 || seg !== 7'b1101101) begin bad++; $display("FAIL blank_d0 edge=%0d got an=%b seg=%b want 001/1101101", n, an, seg); end
      end
      if (e > 10 && e <= 16) begin
        total++; if (an !== 3'b010 || seg !== 7'd0) begin bad++; $display("FAIL blank_d1 edge=%0d got an=%b seg=%b want 010/0", n, an, seg); end
      end
      if (e > 18) begin
        total++; if (an !== 3'b100 || seg !== 7'd0) begin bad++; $display("FAIL blank_d2 edge=%0d got an=%b seg=%b want 100/0", n, an, seg); end
      end
    end
    digi_1 = DIGI_4;
    for (int e = 1; e <= 2 * FLEN; e++) begin
      step();
      if (e > FLEN + 10 && e <= FLEN + 16) begin
        total++; if (an !== 3'b010 || seg !== 7'b1011001) begin bad++; $display("FAIL tens_shown edge=%0d got an=%b seg=%b want 010/1011001", n, an, seg); end
      end
      if (e > FLEN + 18) begin
        total++; if (an !== 3'b100 || seg !== 7'd0) begin bad++; $display("FAIL hundreds_blank edge=%0d got an=%b seg=%b want 100/0", n, an, seg); end
      end
    end
  endtask

  task automatic test_blank_off();
    digi_0 = DIGI_5; digi_1 = DIGI_0; digi_2 = DIGI_0; blank_lead = 1'b0;
    apply_reset();
    run_blank_frames(1, "noblank_frame0");
    for (int e = 1; e <= FLEN; e++) begin
      step();
      // Turning blanking on mid-frame must not affect the frame already captured.
      if (e == 4) blank_lead = 1'b1;
      if ((e > 10 && e <= 16) || e > 18) begin
        total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL noblank_zero edge=%0d got=%b want=0111111", n, seg); end
      end
    end
    run_blank_frames(2, "blank_toggle");
  endtask

  task automatic test_mid_reset();
    digi_0 = DIGI_3; digi_1 = DIGI_2; digi_2 = DIGI_1; blank_lead = 1'b0;
    apply_reset();
    for (int e = 1; e <= 37; e++) step();
    total++; if (an !== 3'b010) begin bad++; $display("FAIL pre_reset_an got=%b want=010", an); end
    rst_n = 1'b0;
    #1;
    total++; if (seg !== 7'd0) begin bad++; $display("FAIL midrst_seg got=%b want=0", seg); end
    total++; if (an !== 3'b000) begin bad++; $display("FAIL midrst_an got=%b want=000", an); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs got=%b want=0", frame_start); end
    apply_reset();
    for (int e = 1; e <= FLEN; e++) begin
      step();
      if (e == 1) begin
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL midrst_first_fs got=%b want=1", frame_start); end
      end
      total++;
      if (seg !== 7'd0 || an !== exp_an) begin
        bad++;
        $display("FAIL midrst_dark edge=%0d got seg=%b an=%b want seg=0 an=%b", n, seg, an, exp_an);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    rst_n = 1'b0;
    test_reset();
    test_first_frame();
    test_dead_time();
    test_coherence();
    test_blanking();
    test_blank_off();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
